dcpu16_busarb: RTL

DCPU16_BUSARB -- requirements
Module: dcpu16_busarb

---
 rtl/dcpu16_busarb.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/dcpu16_busarb.sv
// ----------------------------------------------------------------------------
// dcpu16_busarb
//
// Multi-master to single-slave bus arbiter for a simplified Wishbone memory
// port. Up to NCH masters post requests on m_stb. The arbiter picks one
// channel, either round-robin or by fixed priority, and captures that
// channel's address, write enable and write data into the slave-side request
// registers. It then waits for the slave's ack. If no ack arrives within TMO
// BUSY cycles, the owning channel gets a one-cycle error pulse instead.
//
// Ports
//   clk      in   clock; all state changes on the rising edge
//   rst      in   asynchronous active-low reset
//   m_adr    in   NCH*AW  per-channel address, channel n at [n*AW +: AW]
//   m_stb    in   NCH     per-channel request strobe
//   m_wre    in   NCH     per-channel write enable
//   m_dto    in   NCH*DW  per-channel write data, channel n at [n*DW +: DW]
//   m_dti    out  DW      read data, broadcast to all channels
//   m_ack    out  NCH     per-channel acknowledge (one-hot or zero)
//   m_err    out  NCH     per-channel timeout error (one-hot or zero)
//   s_adr    out  AW      slave address
//   s_stb    out  1       slave request strobe
//   s_wre    out  1       slave write enable
//   s_dto    out  DW      slave write data
//   s_dti    in   DW      slave read data
//   s_ack    in   1       slave acknowledge
//   grant    out  GW      index of the channel owning the slave
//   err_flag out  1       sticky timeout indicator
//   err_clr  in   1       clears err_flag
// ----------------------------------------------------------------------------
module dcpu16_busarb #(
   parameter int AW  = 16,
   parameter int DW  = 16,
   parameter int NCH = 2,
   parameter int RR  = 1,
   parameter int TMO = 255,
   localparam int GW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH*AW-1:0] m_adr,
   input  logic [NCH-1:0]    m_stb,
   input  logic [NCH-1:0]    m_wre,
   input  logic [NCH*DW-1:0] m_dto,
   output logic [DW-1:0]     m_dti,
   output logic [NCH-1:0]    m_ack,
   output logic [NCH-1:0]    m_err,
   output logic [AW-1:0]     s_adr,
   output logic              s_stb,
   output logic              s_wre,
   output logic [DW-1:0]     s_dto,
   input  logic [DW-1:0]     s_dti,
   input  logic              s_ack,
   output logic [GW-1:0]     grant,
   output logic              err_flag,
   input  logic              err_clr
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Value of the wait counter during the last allowed BUSY cycle.
   localparam logic [15:0] CNT_LAST = 16'(TMO - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [15:0]     r_cnt;
   logic [GW-1:0]   r_grant;
   logic [GW-1:0]   r_last;
   logic [AW-1:0]   r_adr;
   logic            r_wre;
   logic [DW-1:0]   r_dto;
   logic            r_stb;
   logic            r_err_flag;

   logic            w_found;
   logic            w_load;
   logic            w_ack_hit;
   logic            w_tmo_hit;
   logic [GW-1:0]   w_sel;
   logic [AW-1:0]   w_sel_adr;
   logic            w_sel_wre;
   logic [DW-1:0]   w_sel_dto;
   int              w_start;
   int              w_dist;
   int              w_best;

   // Channel selection. Every requesting channel gets a distance from the
   // search start (last grant + 1 for round-robin, 0 for fixed priority);
   // the smallest distance wins. Indexing stays constant per loop pass.
   always_comb begin
      w_start   = 0;
      if (RR != 0) begin
         w_start = (int'(r_last) >= NCH - 1) ? 0 : int'(r_last) + 1;
      end
      w_best    = NCH;
      w_dist    = 0;
      w_sel     = '0;
      w_sel_adr = '0;
      w_sel_wre = 1'b0;
      w_sel_dto = '0;
      for (int n = 0; n < NCH; n++) begin
         w_dist = n - w_start;
         if (w_dist < 0) begin
            w_dist = w_dist + NCH;
         end
         if (m_stb[n] && (w_dist < w_best)) begin
            w_best    = w_dist;
            w_sel     = GW'(n);
            w_sel_adr = m_adr[n*AW +: AW];
            w_sel_wre = m_wre[n];
            w_sel_dto = m_dto[n*DW +: DW];
         end
      end
   end

   assign w_found = |m_stb;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state; an ack in the final allowed cycle beats the timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_ack_hit   = 1'b0;
      w_tmo_hit   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_load      = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (s_ack) begin
               w_ack_hit   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_tmo_hit   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Wait counter: cleared when a grant is issued, counts ackless BUSY cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (w_load) begin
         r_cnt <= '0;
      end else if ((r_state == ST_BUSY) && !s_ack && !w_tmo_hit) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   // Request capture. Held untouched for the whole BUSY period, so masters
   // may change or drop their inputs without disturbing the slave cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_adr   <= '0;
         r_wre   <= 1'b0;
         r_dto   <= '0;
         r_grant <= '0;
         r_last  <= GW'(NCH - 1);
         r_stb   <= 1'b0;
      end else if (w_load) begin
         r_adr   <= w_sel_adr;
         r_wre   <= w_sel_wre;
         r_dto   <= w_sel_dto;
         r_grant <= w_sel;
         r_last  <= w_sel;
         r_stb   <= 1'b1;
      end else if (w_ack_hit || w_tmo_hit) begin
         r_stb   <= 1'b0;
      end
   end

   // Sticky error flag; a new timeout overrides a simultaneous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_flag <= 1'b0;
      end else if (w_tmo_hit) begin
         r_err_flag <= 1'b1;
      end else if (err_clr) begin
         r_err_flag <= 1'b0;
      end
   end

   // Per-channel ack/err steering to the current owner.
   always_comb begin
      m_ack = '0;
      m_err = '0;
      for (int n = 0; n < NCH; n++) begin
         m_ack[n] = w_ack_hit && r_stb && (r_grant == GW'(n));
         m_err[n] = w_tmo_hit && r_stb && (r_grant == GW'(n));
      end
   end

   assign m_dti    = s_dti;
   assign s_adr    = r_adr;
   assign s_stb    = r_stb;
   assign s_wre    = r_wre;
   assign s_dto    = r_dto;
   assign grant    = (NCH > 1) ? r_grant : '0;
   assign err_flag = r_err_flag;

endmodule
